// File: rtl/uart_pkg.sv
// Shared types for the UART transmit/receive blocks: FSM state, parity selection
// and the default baud divisor for a 12 MHz clock at 115200 baud.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_t;

  localparam int DEFAULT_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: pulses tick for one cycle every CLKS_PER_BIT cycles;
// clr restarts the period so a frame can align its first bit to the counter.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic fpga_clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // tick must not depend on clr: the transmitter derives clr from tick at a frame boundary
  assign tick = (cnt == LAST);

  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable word width, runtime parity and 1/2 stop bits.
// A one-word holding register behind a valid/ready handshake allows gapless frames.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 fpga_clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           parity_mode,
  output logic                 sout,
  output logic                 busy_tx,
  output logic                 frame_done
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1..2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic [1:0] mode);
    return (^d) ^ (mode == PAR_ODD);
  endfunction

  function automatic logic line_level(input tx_state_t s, input logic b0, input logic pb);
    case (s)
      START:   return 1'b0;
      DATA:    return b0;
      PARITY:  return pb;
      default: return 1'b1;
    endcase
  endfunction

  tx_state_t            state, state_nxt;
  logic [3:0]           bit_cnt, bit_nxt;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic [1:0]           hold_mode;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_en_r, par_bit_r;
  logic                 tick, take, load, frame_end;

  assign take     = tx_valid & ~hold_full;
  assign tx_ready = ~hold_full;
  assign busy_tx  = (state != IDLE) | hold_full;
  assign frame_done = frame_end;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .clr      (load | (state == IDLE)),
    .tick     (tick)
  );

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    load      = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) load = 1'b1;
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt = shift >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_nxt   = '0;
            state_nxt = par_en_r ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_nxt = STOP;
          bit_nxt   = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            frame_end = 1'b1;
            if (hold_full) load = 1'b1;
            else state_nxt = IDLE;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Starting a frame overrides whatever the current state decided
    if (load) begin
      state_nxt = START;
      bit_nxt   = '0;
      shift_nxt = hold_data;
    end
  end

  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      sout      <= 1'b1;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_nxt;
      sout      <= line_level(state_nxt, shift_nxt[0], par_bit_r);
      if (load)      hold_full <= 1'b0;
      else if (take) hold_full <= 1'b1;
    end
  end

  always_ff @(posedge fpga_clk) begin
    shift <= shift_nxt;
    if (take) begin
      hold_data <= tx_data;
      hold_mode <= parity_mode;
    end
    if (load) begin
      par_en_r  <= parity_on(hold_mode);
      par_bit_r <= parity_bit(hold_data, hold_mode);
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: an 8-bit/1-stop instance and a 7-bit/2-stop
// instance, both at CLKS_PER_BIT=4, checked cycle by cycle against built frames.
module tb_uart_tx_frame;

  logic       fpga_clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [8:0] tx_data;
  logic [1:0] parity_mode;
  logic       sel;

  logic ready_a, sout_a, busy_a, done_a;
  logic ready_b, sout_b, busy_b, done_b;
  logic m_ready, m_sout, m_busy, m_done;

  int assertions = 0;
  int failures   = 0;

  always #5 fpga_clk = ~fpga_clk;

  assign m_ready = sel ? ready_b : ready_a;
  assign m_sout  = sel ? sout_b  : sout_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .fpga_clk    (fpga_clk),
    .rst         (rst),
    .tx_valid    (tx_valid & ~sel),
    .tx_ready    (ready_a),
    .tx_data     (tx_data[7:0]),
    .parity_mode (parity_mode),
    .sout        (sout_a),
    .busy_tx     (busy_a),
    .frame_done  (done_a)
  );

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .fpga_clk    (fpga_clk),
    .rst         (rst),
    .tx_valid    (tx_valid & sel),
    .tx_ready    (ready_b),
    .tx_data     (tx_data[6:0]),
    .parity_mode (parity_mode),
    .sout        (sout_b),
    .busy_tx     (busy_b),
    .frame_done  (done_b)
  );

  task automatic check_idle(input string name);
    assertions++;
    if (m_sout !== 1'b1) begin failures++; $display("FAIL %s sout: got %b want 1", name, m_sout); end
    assertions++;
    if (m_ready !== 1'b1) begin failures++; $display("FAIL %s tx_ready: got %b want 1", name, m_ready); end
    assertions++;
    if (m_busy !== 1'b0) begin failures++; $display("FAIL %s busy_tx: got %b want 0", name, m_busy); end
    assertions++;
    if (m_done !== 1'b0) begin failures++; $display("FAIL %s frame_done: got %b want 0", name, m_done); end
  endtask

  // Called 1 time unit after an edge with the selected DUT idle; accepts on the next edge.
  // Inputs are then scrambled so the frame proves they were captured at acceptance.
  task automatic send(input logic [8:0] d, input logic [1:0] pm, input string name);
    tx_valid = 1'b1; tx_data = d; parity_mode = pm;
    @(posedge fpga_clk); #1;
    tx_valid = 1'b0; tx_data = 9'h1FF; parity_mode = 2'b01;
    assertions++;
    if (m_ready !== 1'b0) begin failures++; $display("FAIL %s accept: tx_ready got %b want 0", name, m_ready); end
  endtask

  task automatic check_frame(input logic [8:0] d, input int ndata, input bit par_en,
                             input logic par_val, input int nstop, input string name);
    logic [15:0] bits;
    int nb;
    bits = '0; nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < ndata; i++) begin bits[nb] = d[i]; nb++; end
    if (par_en) begin bits[nb] = par_val; nb++; end
    for (int i = 0; i < nstop; i++) begin bits[nb] = 1'b1; nb++; end
    for (int c = 1; c <= nb * 4; c++) begin
      @(posedge fpga_clk); #1;
      assertions++;
      if (m_sout !== bits[(c-1)/4]) begin
        failures++; $display("FAIL %s sout cycle %0d: got %b want %b", name, c, m_sout, bits[(c-1)/4]);
      end
      assertions++;
      if (m_done !== (c == nb * 4)) begin
        failures++; $display("FAIL %s frame_done cycle %0d: got %b want %b", name, c, m_done, c == nb * 4);
      end
    end
    @(posedge fpga_clk); #1;
    check_idle({name, " end"});
  endtask

  task automatic test_reset();
    sel = 1'b0; rst = 1'b1; tx_valid = 1'b0; tx_data = '0; parity_mode = 2'b00;
    #2;
    check_idle("reset_a");
    sel = 1'b1; check_idle("reset_b"); sel = 1'b0;
    @(posedge fpga_clk); #1; rst = 1'b0;
    repeat (3) @(posedge fpga_clk);
    #1; rst = 1'b1; #1;
    check_idle("reset_idle_pulse");
    @(posedge fpga_clk); #1; rst = 1'b0;
    @(posedge fpga_clk); #1;
    check_idle("reset_idle_after");
  endtask

  task automatic test_8n1();
    sel = 1'b0;
    send(9'h055, 2'b00, "8n1_55");
    check_frame(9'h055, 8, 1'b0, 1'b0, 1, "8n1_55");
  endtask

  task automatic test_parity();
    sel = 1'b0;
    send(9'h007, 2'b01, "even_07");
    check_frame(9'h007, 8, 1'b1, 1'b1, 1, "even_07");
    send(9'h007, 2'b10, "odd_07");
    check_frame(9'h007, 8, 1'b1, 1'b0, 1, "odd_07");
    send(9'h0C3, 2'b11, "mode11_c3");
    check_frame(9'h0C3, 8, 1'b0, 1'b0, 1, "mode11_c3");
  endtask

  task automatic test_back_to_back();
    logic [19:0] bits;
    sel = 1'b0;
    bits = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    tx_valid = 1'b1; tx_data = 9'h0A5; parity_mode = 2'b00;
    @(posedge fpga_clk); #1;
    tx_data = 9'h03C;
    assertions++;
    if (m_ready !== 1'b0) begin failures++; $display("FAIL b2b ready cycle 0: got %b want 0", m_ready); end
    for (int c = 1; c <= 80; c++) begin
      @(posedge fpga_clk); #1;
      if (c == 2) tx_valid = 1'b0;
      assertions++;
      if (m_sout !== bits[(c-1)/4]) begin
        failures++; $display("FAIL b2b sout cycle %0d: got %b want %b", c, m_sout, bits[(c-1)/4]);
      end
      assertions++;
      if (m_ready !== (c == 1 || c >= 41)) begin
        failures++; $display("FAIL b2b tx_ready cycle %0d: got %b want %b", c, m_ready, c == 1 || c >= 41);
      end
      assertions++;
      if (m_done !== (c == 40 || c == 80)) begin
        failures++; $display("FAIL b2b frame_done cycle %0d: got %b want %b", c, m_done, c == 40 || c == 80);
      end
    end
    @(posedge fpga_clk); #1;
    check_idle("b2b end");
  endtask

  task automatic test_7n2();
    sel = 1'b1;
    send(9'h07F, 2'b00, "7n2_7f");
    check_frame(9'h07F, 7, 1'b0, 1'b0, 2, "7n2_7f");
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0;
    send(9'h00A, 2'b00, "rst_mid");
    for (int c = 1; c <= 13; c++) begin
      @(posedge fpga_clk); #1;
      if (c == 1) begin tx_valid = 1'b1; tx_data = 9'h033; parity_mode = 2'b00; end
      if (c == 2) tx_valid = 1'b0;
    end
    assertions++;
    if (m_sout !== 1'b0) begin failures++; $display("FAIL rst_mid bit2: sout got %b want 0", m_sout); end
    assertions++;
    if (m_ready !== 1'b0) begin failures++; $display("FAIL rst_mid held: tx_ready got %b want 0", m_ready); end
    #3; rst = 1'b1; #1;
    check_idle("rst_mid async");
    @(posedge fpga_clk); #1; rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge fpga_clk); #1;
      assertions++;
      if (m_sout !== 1'b1 || m_done !== 1'b0 || m_busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid quiet cycle %0d: sout=%b done=%b busy=%b want 1/0/0", c, m_sout, m_done, m_busy);
      end
    end
    send(9'h03C, 2'b00, "rst_mid_next");
    check_frame(9'h03C, 8, 1'b0, 1'b0, 1, "rst_mid_next");
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_7n2();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
